// File: rtl/switch_pkg.sv
// Constants, tuser field layout and helpers shared by the switch input arbiter
// and the output-port-lookup stage.
package switch_pkg;

    localparam int NUM_QUEUES_DEF = 4;
    localparam int Q_IDX_W        = $clog2(NUM_QUEUES_DEF);
    localparam int SRC_PORT_POS   = 16;
    localparam int DST_PORT_POS   = 24;

    typedef struct packed {
        logic [95:0] rsvd;
        logic [7:0]  dst_port;
        logic [7:0]  src_port;
        logic [15:0] pkt_len;
    } tuser_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axis_skid_2.sv
// Two-entry register slice: push/pop FIFO with occupancy count.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: pushes are only taken while count<2; caller uses count for ready.
module axis_skid_2 #(
    parameter int W = 8
) (
    input  logic         axi_aclk,
    input  logic         axi_reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign pop_vld = (count != 2'd0);
    assign pop     = pop_vld & pop_rdy;
    assign push    = push_vld & (count != 2'd2);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_input_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing the lookup datapath among RX queues.
// Latency: one cycle from input handshake to m_axis through a 2-entry slice.
// Backpressure: input ready comes from registered slice occupancy only.
module switch_input_rr_arbiter
    import switch_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_reset,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                         s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                          m_axis_tvalid,
    output logic                                          m_axis_tlast,
    input  logic                                          m_axis_tready,
    output logic [$clog2(NUM_QUEUES)-1:0]                 grant_q,
    output logic                                          pkt_done
);

    localparam int QW = $clog2(NUM_QUEUES);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int BW = 1 + UW + SW + DW;

    arb_state_t    state, state_nxt;
    logic [QW-1:0] cur_q, cur_q_nxt;
    logic [QW-1:0] rr_ptr, rr_ptr_nxt;
    logic [QW-1:0] sel, gnt_idx, scan_idx;
    logic          pkt_done_nxt;
    logic          any_vld, gnt_vld, slice_rdy, accept;
    logic [1:0]    slice_cnt;
    logic [BW-1:0] in_beat [NUM_QUEUES];
    logic [BW-1:0] gnt_beat;
    logic [BW-1:0] out_beat;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_in
        assign in_beat[i] = {s_axis_tlast[i],
                             s_axis_tuser[i*UW +: UW],
                             s_axis_tstrb[i*SW +: SW],
                             s_axis_tdata[i*DW +: DW]};
    end

    // First valid queue starting at rr_ptr; falls back to rr_ptr when none is valid.
    always_comb begin
        int idx;
        sel      = rr_ptr;
        any_vld  = 1'b0;
        idx      = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            scan_idx = QW'(idx);
            if (!any_vld && s_axis_tvalid[scan_idx]) begin
                any_vld = 1'b1;
                sel     = scan_idx;
            end
        end
    end

    assign gnt_idx   = (state == ST_PKT) ? cur_q : sel;
    assign gnt_vld   = (state == ST_PKT) ? s_axis_tvalid[cur_q] : any_vld;
    assign gnt_beat  = in_beat[gnt_idx];
    assign slice_rdy = (slice_cnt != 2'd2);
    assign accept    = gnt_vld & slice_rdy;
    assign grant_q   = axi_reset ? '0 : gnt_idx;

    always_comb begin
        s_axis_tready = '0;
        if (!axi_reset && slice_rdy && (state == ST_PKT || any_vld)) begin
            s_axis_tready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_q_nxt    = cur_q;
        rr_ptr_nxt   = rr_ptr;
        pkt_done_nxt = 1'b0;
        if (accept) begin
            if (gnt_beat[BW-1]) begin
                // Finished queue drops to lowest priority for the next decision.
                state_nxt    = ST_IDLE;
                rr_ptr_nxt   = QW'(rr_next(int'(gnt_idx), NUM_QUEUES));
                pkt_done_nxt = 1'b1;
            end else if (state == ST_IDLE) begin
                state_nxt = ST_PKT;
                cur_q_nxt = sel;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state    <= ST_IDLE;
            cur_q    <= '0;
            rr_ptr   <= '0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_q    <= cur_q_nxt;
            rr_ptr   <= rr_ptr_nxt;
            pkt_done <= pkt_done_nxt;
        end
    end

    axis_skid_2 #(
        .W (BW)
    ) u_slice (
        .axi_aclk  (axi_aclk),
        .axi_reset (axi_reset),
        .push_vld  (accept),
        .push_dat  (gnt_beat),
        .pop_vld   (m_axis_tvalid),
        .pop_rdy   (m_axis_tready),
        .pop_dat   (out_beat),
        .count     (slice_cnt)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = out_beat;

endmodule

// File: tb/tb_switch_input_rr_arbiter.sv
// Randomized and directed stimulus against a packet-level round-robin reference.
module tb_switch_input_rr_arbiter;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int UW = 32;
    localparam int SW = DW / 8;
    localparam int BW = 1 + UW + SW + DW;

    logic              axi_aclk = 1'b0;
    logic              axi_reset;
    logic [NQ*DW-1:0]  s_axis_tdata;
    logic [NQ*SW-1:0]  s_axis_tstrb;
    logic [NQ*UW-1:0]  s_axis_tuser;
    logic [NQ-1:0]     s_axis_tvalid;
    logic [NQ-1:0]     s_axis_tlast;
    logic [NQ-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [1:0]        grant_q;
    logic              pkt_done;

    switch_input_rr_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .NUM_QUEUES         (NQ)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_q       (grant_q),
        .pkt_done      (pkt_done)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_cmp = 0;
    int n_err = 0;

    // Source side: one packet generator per queue.
    logic [NQ-1:0] v, lst, acc, en, rdy_seen;
    logic [DW-1:0] d  [NQ];
    logic [SW-1:0] st [NQ];
    logic [UW-1:0] us [NQ];
    int beat[NQ], len[NQ], seq[NQ], fixlen[NQ], vprob[NQ], stall_at[NQ], stall_cnt[NQ];
    int mrdy;

    // Reference: packet owner, next-priority queue, and beats held in the slice.
    logic [BW-1:0] fifo [$];
    int owner, ptr;
    logic done_pend;
    int obs_beats, obs_done, obs_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        owner = -1;
        ptr = 0;
        done_pend = 1'b0;
        acc = '0;
    endtask

    task automatic src_reset();
        for (int q = 0; q < NQ; q++) begin
            beat[q] = 0; len[q] = 1; seq[q] = 0; fixlen[q] = 0; vprob[q] = 100;
            stall_at[q] = 0; stall_cnt[q] = 0;
            d[q] = '0; st[q] = '0; us[q] = '0;
        end
        v = '0; lst = '0; en = '0; mrdy = 100;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0;
    endtask

    task automatic gen_beat(input int q);
        d[q] = {$urandom, $urandom};
        d[q][DW-1 -: 24] = {8'(q), 8'(seq[q]), 8'(beat[q])};
        st[q] = 8'($urandom);
        us[q] = $urandom;
        lst[q] = (beat[q] == len[q] - 1);
    endtask

    task automatic drive();
        bit go;
        for (int q = 0; q < NQ; q++) begin
            if (acc[q]) begin
                v[q] = 1'b0;
                if (lst[q]) begin
                    beat[q] = 0;
                    seq[q]++;
                end else begin
                    beat[q]++;
                end
            end
            if (!v[q]) begin
                if (beat[q] == 0) begin
                    go = en[q] && (int'($urandom_range(99)) < vprob[q]);
                end else if (stall_cnt[q] > 0 && beat[q] == stall_at[q]) begin
                    go = 1'b0;
                    stall_cnt[q]--;
                end else begin
                    go = (int'($urandom_range(99)) < vprob[q]);
                end
                if (go) begin
                    if (beat[q] == 0) len[q] = (fixlen[q] != 0) ? fixlen[q] : int'($urandom_range(1, 4));
                    v[q] = 1'b1;
                    gen_beat(q);
                end
            end
            s_axis_tdata[q*DW +: DW] = d[q];
            s_axis_tstrb[q*SW +: SW] = st[q];
            s_axis_tuser[q*UW +: UW] = us[q];
        end
        s_axis_tvalid = v;
        s_axis_tlast  = lst;
        m_axis_tready = (int'($urandom_range(99)) < mrdy);
    endtask

    task automatic model_step();
        int g;
        int q;
        logic [NQ-1:0] exp_rdy;
        int exp_gq;
        g = -1;
        if (owner >= 0) begin
            g = owner;
        end else begin
            for (int k = 0; k < NQ; k++) begin
                q = (ptr + k) % NQ;
                if (g < 0 && v[q]) g = q;
            end
        end
        exp_rdy = '0;
        if (g >= 0 && fifo.size() < 2) exp_rdy[g] = 1'b1;
        exp_gq = (g >= 0) ? g : ptr;

        obs_beats += int'(m_axis_tvalid & m_axis_tready);
        obs_done  += int'(pkt_done);
        obs_in    += int'(|(s_axis_tvalid & s_axis_tready));
        rdy_seen  |= s_axis_tready;

        chk("s_tready", 128'(s_axis_tready), 128'(exp_rdy));
        chk("grant_q", 128'(grant_q), 128'(exp_gq));
        chk("pkt_done", 128'(pkt_done), 128'(done_pend));
        chk("m_tvalid", 128'(m_axis_tvalid), 128'(fifo.size() != 0));
        if (fifo.size() != 0)
            chk("m_beat", 128'({m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}), 128'(fifo[0]));

        if (fifo.size() != 0 && m_axis_tready) void'(fifo.pop_front());
        done_pend = 1'b0;
        acc = '0;
        if (g >= 0 && exp_rdy[g] && v[g]) begin
            acc[g] = 1'b1;
            fifo.push_back({lst[g], us[g], st[g], d[g]});
            if (lst[g]) begin
                owner = -1;
                ptr = (g + 1) % NQ;
                done_pend = 1'b1;
            end else begin
                owner = g;
            end
        end
    endtask

    task automatic tick();
        @(negedge axi_aclk);
        model_step();
        @(posedge axi_aclk);
        #1;
        drive();
    endtask

    function automatic bit src_active();
        for (int q = 0; q < NQ; q++) if (v[q] || beat[q] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        en = '0;
        mrdy = 100;
        while ((owner >= 0 || fifo.size() != 0 || src_active()) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_bound", 128'(n < 300), 128'(1));
    endtask

    task automatic clear_obs();
        obs_beats = 0; obs_done = 0; obs_in = 0; rdy_seen = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
        chk({tag, "_m_tlast"}, 128'(m_axis_tlast), 128'(0));
        chk({tag, "_m_data"}, 128'({m_axis_tuser, m_axis_tstrb, m_axis_tdata}), 128'(0));
        chk({tag, "_s_tready"}, 128'(s_axis_tready), 128'(0));
        chk({tag, "_grant_q"}, 128'(grant_q), 128'(0));
        chk({tag, "_pkt_done"}, 128'(pkt_done), 128'(0));
    endtask

    initial begin
        int n;
        int start_sz;
        axi_reset = 1'b1;
        m_axis_tready = 1'b0;
        src_reset();
        model_reset();
        clear_obs();
        #7;
        check_reset_outputs("rst0");
        @(negedge axi_aclk);
        #2 axi_reset = 1'b0;

        // All queues backlogged with 2-beat packets from rr_ptr=0.
        for (int q = 0; q < NQ; q++) fixlen[q] = 2;
        en = '1;
        for (int i = 0; i < 4; i++) tick();
        clear_obs();
        for (int i = 0; i < 16; i++) tick();
        chk("backlog_beats", 128'(obs_beats), 128'(16));
        chk("backlog_done", 128'(obs_done), 128'(8));
        drain();

        // Single 3-beat packet from q2.
        clear_obs();
        fixlen[2] = 3;
        en = 4'b0100;
        tick();
        en = '0;
        drain();
        chk("q2_done", 128'(obs_done), 128'(1));
        chk("q2_beats", 128'(obs_beats), 128'(3));
        chk("q2_rr_ptr", 128'(grant_q), 128'(3));

        // q1 stalls mid-packet while q0 and q3 wait.
        fixlen[1] = 4; fixlen[0] = 2; fixlen[3] = 2;
        stall_at[1] = 2; stall_cnt[1] = 5;
        en = 4'b0010;
        n = 0;
        while (beat[1] < 1 && n < 20) begin tick(); n++; end
        chk("stall_start_bound", 128'(n < 20), 128'(1));
        en = 4'b1001;
        rdy_seen = '0;
        n = 0;
        while (beat[1] != 0 && n < 50) begin tick(); n++; end
        chk("stall_end_bound", 128'(n < 50), 128'(1));
        chk("stall_others_rdy", 128'(rdy_seen & 4'b1001), 128'(0));
        chk("stall_cycles", 128'(stall_cnt[1]), 128'(0));
        drain();

        // Output backpressure for 10 cycles mid-packet.
        fixlen[0] = 6;
        en = 4'b0001;
        n = 0;
        while (beat[0] < 1 && n < 20) begin tick(); n++; end
        chk("bp_start_bound", 128'(n < 20), 128'(1));
        en = '0;
        mrdy = 0;
        tick();
        start_sz = fifo.size();
        clear_obs();
        for (int i = 0; i < 10; i++) tick();
        chk("bp_accepted", 128'(obs_in), 128'(2 - start_sz));
        chk("bp_no_output", 128'(obs_beats), 128'(0));
        clear_obs();
        drain();
        chk("bp_done", 128'(obs_done), 128'(1));

        // Single-beat packets alternating between q0 and q1.
        fixlen[0] = 1; fixlen[1] = 1;
        en = 4'b0011;
        for (int i = 0; i < 4; i++) tick();
        clear_obs();
        for (int i = 0; i < 20; i++) tick();
        chk("alt_beats", 128'(obs_beats), 128'(20));
        chk("alt_done", 128'(obs_done), 128'(20));
        drain();

        // Random soak.
        for (int q = 0; q < NQ; q++) begin fixlen[q] = 0; vprob[q] = 60; end
        en = '1;
        mrdy = 70;
        for (int i = 0; i < 400; i++) tick();
        drain();

        // Asynchronous reset mid-packet, then a fresh q3 packet.
        for (int q = 0; q < NQ; q++) vprob[q] = 100;
        fixlen[0] = 5;
        en = 4'b0001;
        n = 0;
        while (beat[0] < 2 && n < 20) begin tick(); n++; end
        chk("rst_start_bound", 128'(n < 20), 128'(1));
        #3 axi_reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        src_reset();
        model_reset();
        @(negedge axi_aclk);
        check_reset_outputs("rst_hold");
        #2 axi_reset = 1'b0;
        clear_obs();
        fixlen[3] = 3;
        en = 4'b1000;
        tick();
        en = '0;
        drain();
        chk("post_rst_done", 128'(obs_done), 128'(1));
        chk("post_rst_beats", 128'(obs_beats), 128'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
